// File: rtl/tf32_pkg.sv
// Shared TF32 (1-8-10) field layout, constants and divider state encoding.
// Used by both the divider and the approximate multiplier datapath.
package tf32_pkg;
    localparam int SIGN_BIT = 18;
    localparam int EXP_MSB  = 17;
    localparam int EXP_LSB  = 10;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 10;
    localparam int SIG_W    = 11;
    localparam int REM_W    = 12;
    localparam int BIAS     = 127;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } div_state_e;
endpackage

// File: rtl/tf32_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module tf32_div_step
    import tf32_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [SIG_W-1:0] mb,
    output logic [REM_W-1:0] rem_next,
    output logic             qbit
);
    logic [REM_W-1:0] diff;

    // rem stays below 2*mb, so the bit shifted out of the top is always zero
    always_comb begin
        diff     = rem - {1'b0, mb};
        qbit     = (rem >= {1'b0, mb});
        rem_next = qbit ? {diff[REM_W-2:0], 1'b0} : {rem[REM_W-2:0], 1'b0};
    end
endmodule

// File: rtl/tf32_div_seq.sv
// Sequential TF32 divider: restoring radix-2 over 11-bit significands,
// truncating, no subnormals, valid/ready on both sides, fixed latency.
module tf32_div_seq
    import tf32_pkg::*;
#(
    parameter int W_TF32 = 19,
    parameter int BIAS   = 127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_TF32-1:0] a,
    input  logic [W_TF32-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_TF32-1:0] q,
    output logic              out_dz
);
    div_state_e        state_q;
    logic [3:0]        cnt_q;
    logic [REM_W-1:0]  rem_q;
    logic [REM_W-1:0]  qb_q;
    logic [SIG_W-1:0]  mb_q;
    logic signed [9:0] exp_q;
    logic              sign_q;
    logic              dz_flag_q;
    logic              zero_q;
    logic [W_TF32-1:0] q_q;
    logic              out_dz_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [9:0]        e_d;
    logic [REM_W-1:0]  rem_d;
    logic              qbit_d;
    logic signed [9:0] exp_n;
    logic [MANT_W-1:0] mant_n;
    logic [W_TF32-1:0] q_d;

    tf32_div_step u_step (
        .rem      (rem_q),
        .mb       (mb_q),
        .rem_next (rem_d),
        .qbit     (qbit_d)
    );

    assign e_d = {2'b00, a[EXP_MSB:EXP_LSB]} - {2'b00, b[EXP_MSB:EXP_LSB]} + 10'(BIAS);

    always_comb begin
        mant_n = qb_q[REM_W-1] ? qb_q[MANT_W:1] : qb_q[MANT_W-1:0];
        exp_n  = qb_q[REM_W-1] ? exp_q : exp_q - 10'sd1;
        if (dz_flag_q)
            q_d = {sign_q, EXP_MAX, {MANT_W{1'b0}}};
        else if (zero_q)
            q_d = {sign_q, 8'h00, {MANT_W{1'b0}}};
        else if (exp_n >= 10'sd255)
            q_d = {sign_q, EXP_MAX, {MANT_W{1'b0}}};
        else if (exp_n <= 10'sd0)
            q_d = {sign_q, 8'h00, {MANT_W{1'b0}}};
        else
            q_d = {sign_q, exp_n[7:0], mant_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            qb_q        <= '0;
            mb_q        <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            dz_flag_q   <= 1'b0;
            zero_q      <= 1'b0;
            q_q         <= '0;
            out_dz_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= a[SIGN_BIT] ^ b[SIGN_BIT];
                        rem_q      <= {1'b0, 1'b1, a[MANT_W-1:0]};
                        mb_q       <= {1'b1, b[MANT_W-1:0]};
                        exp_q      <= e_d;
                        dz_flag_q  <= (b[EXP_MSB:EXP_LSB] == 8'h00);
                        zero_q     <= (a[EXP_MSB:EXP_LSB] == 8'h00);
                        qb_q       <= '0;
                        cnt_q      <= 4'(SIG_W);
                        in_ready_q <= 1'b0;
                        state_q    <= DIV;
                    end
                end
                DIV: begin
                    // quotient bits arrive MSB first, so shifting in lands bit cnt at qb[cnt]
                    qb_q  <= {qb_q[REM_W-2:0], qbit_d};
                    rem_q <= rem_d;
                    if (cnt_q == 4'd0)
                        state_q <= NORM;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                NORM: begin
                    q_q      <= q_d;
                    out_dz_q <= dz_flag_q;
                    state_q  <= DONE;
                end
                DONE: begin
                    // result registers settle for one cycle before being presented
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign out_dz    = out_dz_q;
endmodule

// File: tb/tb_tf32_div_seq.sv
// Directed vector bench for tf32_div_seq: table of divisions plus
// back-pressure and mid-operation reset sequences.
module tb_tf32_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [18:0] a = '0;
    logic [18:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_dz;
    logic [18:0] q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tf32_div_seq #(.W_TF32(19), .BIAS(127)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .out_dz    (out_dz)
    );

    typedef struct {
        logic [18:0] a;
        logic [18:0] b;
        logic [18:0] q;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Starts and ends on a negedge; lat is the number of rising edges after
    // the accept edge until out_valid is seen, or -1 if it never appears.
    task automatic run_op(input logic [18:0] ta, input logic [18:0] tb_,
                          output logic [18:0] rq, output logic rdz, output int lat);
        int waited;
        lat    = -1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 19'($urandom);
        b = 19'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        rq  = q;
        rdz = out_dz;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[14];
        logic [18:0] rq;
        logic        rdz;
        int          lat;
        int          seen;

        vecs[0]  = '{a: 19'h20600, b: 19'h20000, q: 19'h20200, dz: 1'b0}; // 6/2
        vecs[1]  = '{a: 19'h1FC00, b: 19'h20200, q: 19'h1F555, dz: 1'b0}; // 1/3
        vecs[2]  = '{a: 19'h5FC00, b: 19'h20000, q: 19'h5F800, dz: 1'b0}; // -1/2
        vecs[3]  = '{a: 19'h20000, b: 19'h00000, q: 19'h3FC00, dz: 1'b1}; // x/0
        vecs[4]  = '{a: 19'h00400, b: 19'h32000, q: 19'h00000, dz: 1'b0}; // underflow
        vecs[5]  = '{a: 19'h3F800, b: 19'h00400, q: 19'h3FC00, dz: 1'b0}; // overflow
        vecs[6]  = '{a: 19'h40000, b: 19'h20000, q: 19'h40000, dz: 1'b0}; // -0/2
        vecs[7]  = '{a: 19'h00000, b: 19'h40000, q: 19'h7FC00, dz: 1'b1}; // 0/-0
        vecs[8]  = '{a: 19'h3FC00, b: 19'h3FC00, q: 19'h1FC00, dz: 1'b0}; // exp255 operands
        vecs[9]  = '{a: 19'h00400, b: 19'h1FE00, q: 19'h00000, dz: 1'b0}; // exp lands on 0
        vecs[10] = '{a: 19'h3F800, b: 19'h1FC00, q: 19'h3F800, dz: 1'b0}; // exp 254 kept
        vecs[11] = '{a: 19'h3FC00, b: 19'h1FC00, q: 19'h3FC00, dz: 1'b0}; // exp 255 clamp
        vecs[12] = '{a: 19'h00800, b: 19'h1FE00, q: 19'h00555, dz: 1'b0}; // exp lands on 1
        vecs[13] = '{a: 19'h60600, b: 19'h60000, q: 19'h20200, dz: 1'b0}; // -6/-2

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset q", 32'(q), 32'd0);
        check("reset out_dz", 32'(out_dz), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, rq, rdz, lat);
            $display("op %0d: a=%h b=%h q=%h dz=%b lat=%0d", i, vecs[i].a, vecs[i].b, rq, rdz, lat);
            check($sformatf("vec%0d q", i), 32'(rq), 32'(vecs[i].q));
            check($sformatf("vec%0d dz", i), 32'(rdz), 32'(vecs[i].dz));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd14);
            check($sformatf("vec%0d in_ready after consume", i), 32'(in_ready), 32'd1);
        end

        // Back-pressure: result held, second request ignored
        a = 19'h20600;
        b = 19'h20000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("bp latency", 32'(lat), 32'd14);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            a = 19'h1FC00;
            b = 19'h20200;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp hold%0d q", c), 32'(q), 32'h20200);
            check($sformatf("bp hold%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp hold%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        $display("op bp: a=20600 b=20000 held 5 cycles, q=20200 expected");
        check("bp out_valid after consume", 32'(out_valid), 32'd0);
        check("bp in_ready after consume", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp ignored request produced no result", 32'(seen), 32'd0);

        // Reset in the middle of the iteration
        a = 19'h20600;
        b = 19'h20000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset in_ready after release", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        $display("op rst: aborted 6/2 at cycle 6, out_valid pulses=%0d", seen);
        check("midreset lost op never completes", 32'(seen), 32'd0);
        run_op(19'h20600, 19'h20000, rq, rdz, lat);
        $display("op post-reset: a=20600 b=20000 q=%h dz=%b lat=%0d", rq, rdz, lat);
        check("post-reset q", 32'(rq), 32'h20200);
        check("post-reset dz", 32'(rdz), 32'd0);
        check("post-reset latency", 32'(lat), 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
